// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-programmable N-bit serial pattern detector with valid
// qualifier, selectable overlapping/non-overlapping matches and a saturating match counter.
module seq_detect_param #(
    parameter int             N        = 4,
    parameter logic [N-1:0]   PAT_INIT = 4'b1011,
    parameter int             CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_vld,
    input  logic [N-1:0]     pat,
    input  logic             pat_load,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             dout,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);
    localparam int            FW   = $clog2(N + 1);
    localparam logic [FW-1:0] FULL = FW'(N);

    logic [N-1:0]     r_hist;
    logic [N-1:0]     r_pat;
    logic [FW-1:0]    r_fill;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dout;
    logic             r_sat;
    logic [N-1:0]     w_hist_nx;
    logic [FW-1:0]    w_fill_nx;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_hit;
    logic             w_restart;

    // fill guards against false matches on the zeroed history after reset/load/restart
    always_comb begin
        w_hist_nx = {r_hist[N-2:0], din};
        w_fill_nx = (r_fill == FULL) ? FULL : r_fill + 1'b1;
        w_hit     = din_vld && !pat_load && (w_fill_nx == FULL) && (w_hist_nx == r_pat);
        w_restart = w_hit && !overlap;
        w_cnt_inc = r_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist <= '0;
            r_fill <= '0;
            r_pat  <= PAT_INIT;
            r_dout <= 1'b0;
            r_cnt  <= '0;
            r_sat  <= 1'b0;
        end else begin
            if (pat_load) begin
                r_pat  <= pat;
                r_hist <= '0;
                r_fill <= '0;
            end else if (din_vld) begin
                r_hist <= w_restart ? '0 : w_hist_nx;
                r_fill <= w_restart ? '0 : w_fill_nx;
            end
            r_dout <= w_hit;
            if (cnt_clr) begin
                r_cnt <= '0;
                r_sat <= 1'b0;
            end else if (w_hit && !(&r_cnt)) begin
                r_cnt <= w_cnt_inc;
                r_sat <= &w_cnt_inc;
            end
        end
    end

    assign dout      = r_dout;
    assign match_cnt = r_cnt;
    assign cnt_sat   = r_sat;
endmodule
